// File: rtl/ofm_resize_pkg.sv
// Shared types and widths for the output-side 1536->512 resize buffer.
package ofm_resize_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StLoad,
        StSend
    } state_e;

    localparam int unsigned OFM_REG_NUM = 3;
    localparam int unsigned BEAT_W      = 512;
    localparam int unsigned BEAT_CNT_W  = $clog2(OFM_REG_NUM);
    localparam int unsigned WORD_CNT_W  = 16;

endpackage

// File: rtl/ofm_resizebuffer_fifo.sv
// FifoType0: single-clock FIFO with registered pop data and synchronous CLEAR.
module FifoType0 #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_bits  = 4
) (
    input  logic                  clk,
    input  logic                  nRESET,
    input  logic                  CLEAR,
    input  logic                  PUSH_REQ,
    input  logic [data_width-1:0] PUSH_DATA,
    input  logic                  POP_REQ,
    output logic [data_width-1:0] POP_DATA,
    output logic                  FULL,
    output logic                  EMPTY
);

    localparam int unsigned Depth = 2 ** addr_bits;

    logic [data_width-1:0] mem [Depth];
    logic [addr_bits-1:0]  wr_ptr, rd_ptr;
    logic [addr_bits:0]    count;
    logic                  do_push, do_pop;

    assign FULL    = (count == (addr_bits + 1)'(Depth));
    assign EMPTY   = (count == '0);
    assign do_push = PUSH_REQ & ~FULL;
    assign do_pop  = POP_REQ & ~EMPTY;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            POP_DATA <= '0;
        end else if (CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                POP_DATA <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= PUSH_DATA;
    end

endmodule

// File: rtl/ofm_resizebuffer.sv
// Buffers wide PE result words and serialises each into REG_NUM stream beats.
// Define OFM_RESIZE_TLAST_EN to enable word counting, out_last and done.
module ofm_resizebuffer
    import ofm_resize_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH    = 1536,
    parameter int unsigned OUTPUT_WIDTH   = BEAT_W,
    parameter int unsigned REG_NUM        = OFM_REG_NUM,
    parameter int unsigned FIFO_ADDR_BITS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_start,
    input  logic                    end_conv,
    input  logic [WORD_CNT_W-1:0]   total_words,
    input  logic                    res_valid,
    input  logic [INPUT_WIDTH-1:0]  res_data,
    output logic                    res_full,
    output logic                    out_valid,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    done,
    output logic                    overflow
);

    state_e                                 state_q, state_d;
    logic                                   fifo_full, fifo_empty, pop_req;
    logic [INPUT_WIDTH-1:0]                 pop_data, hold_r;
    logic [REG_NUM-1:0][OUTPUT_WIDTH-1:0]   hold_beats;
    logic [BEAT_CNT_W-1:0]                  beat_cnt;
    logic                                   hs, last_beat, last_word, done_d;

    FifoType0 #(
        .data_width (INPUT_WIDTH),
        .addr_bits  (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .nRESET    (~rst),
        .CLEAR     (end_conv),
        .PUSH_REQ  (res_valid),
        .PUSH_DATA (res_data),
        .POP_REQ   (pop_req),
        .POP_DATA  (pop_data),
        .FULL      (fifo_full),
        .EMPTY     (fifo_empty)
    );

    assign res_full   = fifo_full;
    assign out_valid  = (state_q == StSend);
    assign hs         = (state_q == StSend) & out_ready;
    assign last_beat  = (beat_cnt == BEAT_CNT_W'(REG_NUM - 1));
    assign hold_beats = hold_r;
    assign out_data   = hold_beats[beat_cnt];

`ifdef OFM_RESIZE_TLAST_EN
    logic [WORD_CNT_W-1:0] word_cnt, total_r;
    assign last_word = (word_cnt == total_r - 1'b1);
`else
    logic unused_total;
    assign unused_total = ^total_words;
    assign last_word    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (end_conv) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_start) begin
`ifdef OFM_RESIZE_TLAST_EN
                        state_d = (total_words == '0) ? StIdle : StPop;
`else
                        state_d = StPop;
`endif
                    end
                end
                StPop:  if (!fifo_empty) state_d = StLoad;
                StLoad: state_d = StSend;
                StSend: begin
                    if (hs && last_beat) begin
                        if (last_word)        state_d = StIdle;
                        else if (!fifo_empty) state_d = StLoad;
                        else                  state_d = StPop;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pop_req  = 1'b0;
        done_d   = 1'b0;
        out_last = 1'b0;
        if (!end_conv) begin
            unique case (state_q)
                StPop:  pop_req = !fifo_empty;
                // Back-to-back pop on the final beat hides one cycle of FIFO latency.
                StSend: pop_req = hs && last_beat && !last_word && !fifo_empty;
                default: pop_req = 1'b0;
            endcase
        end
`ifdef OFM_RESIZE_TLAST_EN
        out_last = (state_q == StSend) && last_beat && last_word;
        if (!end_conv) begin
            if (state_q == StIdle) done_d = op_start && (total_words == '0);
            if (state_q == StSend) done_d = hs && last_beat && last_word;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r   <= '0;
            beat_cnt <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
`ifdef OFM_RESIZE_TLAST_EN
            word_cnt <= '0;
            total_r  <= '0;
`endif
        end else begin
            done <= done_d;
            if (op_start)                    overflow <= 1'b0;
            else if (res_valid && fifo_full) overflow <= 1'b1;

            if (end_conv) begin
                beat_cnt <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (op_start) begin
                            beat_cnt <= '0;
`ifdef OFM_RESIZE_TLAST_EN
                            word_cnt <= '0;
                            total_r  <= total_words;
`endif
                        end
                    end
                    StLoad: begin
                        hold_r   <= pop_data;
                        beat_cnt <= '0;
                    end
                    StSend: begin
                        if (hs) begin
                            if (last_beat) begin
                                beat_cnt <= '0;
`ifdef OFM_RESIZE_TLAST_EN
                                word_cnt <= word_cnt + 1'b1;
`endif
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    default: beat_cnt <= beat_cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ofm_resizebuffer.sv
// Directed self-checking bench for ofm_resizebuffer (with or without OFM_RESIZE_TLAST_EN).
module tb_ofm_resizebuffer;

`ifdef OFM_RESIZE_TLAST_EN
    localparam bit TLAST = 1'b1;
`else
    localparam bit TLAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          op_start, end_conv, res_valid, out_ready;
    logic [15:0]   total_words;
    logic [1535:0] res_data;
    logic          res_full, out_valid, out_last, done, overflow;
    logic [511:0]  out_data;

    int n_total = 0;
    int n_bad   = 0;
    int done_hits = 0;
    int last_hits = 0;
    int cyc, vcnt;

    ofm_resizebuffer dut (
        .clk         (clk),
        .rst         (rst),
        .op_start    (op_start),
        .end_conv    (end_conv),
        .total_words (total_words),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_full    (res_full),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_hits++;
        if (out_last && out_valid && out_ready) last_hits++;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] beat(input int w, input int b);
        logic [31:0] unit;
        unit = {8'(w), 8'(b), 16'(w * 7 + b + 1)};
        return {16{unit}};
    endfunction

    function automatic logic [1535:0] word(input int w);
        return {beat(w, 2), beat(w, 1), beat(w, 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int w);
        res_valid = 1'b1;
        res_data  = word(w);
        tick();
        res_valid = 1'b0;
    endtask

    task automatic start(input int n);
        op_start    = 1'b1;
        total_words = 16'(n);
        tick();
        op_start = 1'b0;
    endtask

    task automatic abort();
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
    endtask

    // Accept beats, checking every valid cycle against the next expected beat.
    task automatic drain(input int first, input int nwords, input bit toggle,
                         input int abort_at, output int cycles);
        int k, total;
        k = 0;
        cycles = 0;
        total = nwords * 3;
        while (k < total && cycles < total * 4 + 40) begin
            if (out_valid && k == abort_at) begin
                out_ready = 1'b1;
                abort();
                out_ready = 1'b0;
                return;
            end
            out_ready = toggle ? (cycles % 2 == 0) : 1'b1;
            if (out_valid) begin
                check("beat_data", out_data, beat(first + k / 3, k % 3));
                if (out_ready) begin
                    check("beat_last", 512'(out_last), 512'(TLAST && k == total - 1));
                    k++;
                end
            end
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        if (k < total) check("drain_timeout", 512'(k), 512'(total));
    endtask

    initial begin
        rst = 1'b1; op_start = 0; end_conv = 0; res_valid = 0; out_ready = 0;
        total_words = '0; res_data = '0;
        tick(); tick();
        check("rst_valid", 512'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_last", 512'(out_last), 0);
        check("rst_done", 512'(done), 0);
        check("rst_ovf", 512'(overflow), 0);
        check("rst_full", 512'(res_full), 0);
        rst = 1'b0;
        tick();

        // Basic split with latency
        start(1);
        push(1);
        check("lat_t1", 512'(out_valid), 0);
        tick();
        check("lat_t2", 512'(out_valid), 0);
        tick();
        check("lat_t3", 512'(out_valid), 1);
        drain(1, 1, 1'b0, -1, cyc);
        check("basic_cycles", 512'(cyc), 3);
        check("basic_done", 512'(done), 512'(TLAST));
        tick();
        check("basic_done_off", 512'(done), 0);
        abort();

        // Backpressure
        start(4);
        for (int i = 0; i < 4; i++) push(10 + i);
        drain(10, 4, 1'b1, -1, cyc);
        check("bp_done", 512'(done), 512'(TLAST));
        abort();

        // FIFO full and overflow, filled while idle
        for (int i = 0; i < 1023; i++) push(i);
        check("full_1023", 512'(res_full), 0);
        push(1023);
        check("full_1024", 512'(res_full), 1);
        check("ovf_before", 512'(overflow), 0);
        push(4000);
        check("ovf_after", 512'(overflow), 1);
        check("full_still", 512'(res_full), 1);
        start(1024);
        check("ovf_cleared", 512'(overflow), 0);
        drain(0, 1024, 1'b0, -1, cyc);
        check("full_done", 512'(done), 512'(TLAST));
        check("full_drained", 512'(res_full), 0);
        tick();
        check("full_no_extra", 512'(out_valid), 0);
        abort();

        // Abort during beat 1 of word 2
        start(3);
        for (int i = 0; i < 3; i++) push(100 + i);
        drain(100, 3, 1'b0, 4, cyc);
        check("abort_valid", 512'(out_valid), 0);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin tick(); vcnt += int'(out_valid); end
        start(1);
        for (int i = 0; i < 5; i++) begin vcnt += int'(out_valid); tick(); end
        check("abort_empty", 512'(vcnt), 0);
        push(50);
        drain(50, 1, 1'b0, -1, cyc);
        check("abort_new_done", 512'(done), 512'(TLAST));
        abort();

        // Reset mid-stream
        start(2);
        push(200);
        push(201);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        check("rs_sending", 512'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("rs_valid", 512'(out_valid), 0);
        check("rs_data", out_data, 0);
        check("rs_last", 512'(out_last), 0);
        check("rs_done", 512'(done), 0);
        check("rs_full", 512'(res_full), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); vcnt += int'(out_valid); end
        start(1);
        for (int i = 0; i < 4; i++) begin vcnt += int'(out_valid); tick(); end
        check("rs_quiet", 512'(vcnt), 0);
        push(77);
        drain(77, 1, 1'b0, -1, cyc);
        check("rs_new_done", 512'(done), 512'(TLAST));
        abort();

        // total_words = 0
        start(0);
        check("zero_done", 512'(done), 512'(TLAST));
        check("zero_valid", 512'(out_valid), 0);
        tick();
        check("zero_done_off", 512'(done), 0);
        abort();

        // Five words preloaded, steady-state throughput
        for (int i = 0; i < 5; i++) push(300 + i);
        start(5);
        drain(300, 5, 1'b0, -1, cyc);
        check("five_cycles", 512'(cyc), 21);
        check("five_done", 512'(done), 512'(TLAST));
        tick();
        abort();

        check("done_hits", 512'(done_hits), TLAST ? 7 : 0);
        check("last_hits", 512'(last_hits), TLAST ? 6 : 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
